// File: rtl/l2cache_control_pkg.sv
// Shared widths and types for the L2 cache controller and its datapath hooks.
package l2cache_control_pkg;

    localparam int unsigned L2_WAYS    = 4;
    localparam int unsigned L2_WAY_W   = 2;
    localparam int unsigned L2_PLRU_W  = 3;
    localparam int unsigned MISS_CNT_W = 16;

    typedef logic [L2_WAY_W-1:0]   lc3b_l2_way;
    typedef logic [L2_PLRU_W-1:0]  lc3b_l2_plru;
    typedef logic [L2_WAYS-1:0]    lc3b_l2_way_mask;
    typedef logic [MISS_CNT_W-1:0] l2_miss_count_t;

    // One-hot per-way enable selecting way w.
    function automatic lc3b_l2_way_mask way_onehot(input lc3b_l2_way w);
        return lc3b_l2_way_mask'(1) << w;
    endfunction

endpackage

// File: rtl/l2cache_control_if.sv
// CPU bus, memory bus and datapath control signals of the L2 cache controller.
interface l2cache_control_if;
    import l2cache_control_pkg::*;

    // CPU side
    logic            cpu_cyc;
    logic            cpu_stb;
    logic            cpu_we;
    logic            cpu_ack;
    // Memory side
    logic            mem_cyc;
    logic            mem_stb;
    logic            mem_we;
    logic            mem_ack;
    // Datapath status
    logic            hit;
    lc3b_l2_way      hit_way;
    logic            victim_dirty;
    lc3b_l2_plru     plru_out;
    // Datapath control
    logic            plru_write;
    lc3b_l2_plru     plru_in;
    lc3b_l2_way      victim_way;
    lc3b_l2_way_mask way_write;
    lc3b_l2_way_mask valid_write;
    logic            valid_in;
    lc3b_l2_way_mask dirty_write;
    logic            dirty_in;
    logic            datainmux_sel;
    logic            memaddrmux_sel;
    l2_miss_count_t  miss_count;

    // Controller view.
    modport master (
        input  cpu_cyc, cpu_stb, cpu_we, mem_ack,
        input  hit, hit_way, victim_dirty, plru_out,
        output cpu_ack, mem_cyc, mem_stb, mem_we,
        output plru_write, plru_in, victim_way,
        output way_write, valid_write, valid_in,
        output dirty_write, dirty_in,
        output datainmux_sel, memaddrmux_sel, miss_count
    );

    // Environment view (CPU, memory and datapath together).
    modport slave (
        output cpu_cyc, cpu_stb, cpu_we, mem_ack,
        output hit, hit_way, victim_dirty, plru_out,
        input  cpu_ack, mem_cyc, mem_stb, mem_we,
        input  plru_write, plru_in, victim_way,
        input  way_write, valid_write, valid_in,
        input  dirty_write, dirty_in,
        input  datainmux_sel, memaddrmux_sel, miss_count
    );

endinterface

// File: rtl/l2plru_logic.sv
// Tree pseudo-LRU for a 4-way set: victim selection and post-access update.
module l2plru_logic
    import l2cache_control_pkg::*;
(
    input  lc3b_l2_plru plru_i,
    input  lc3b_l2_way  access_way_i,
    output lc3b_l2_way  victim_c_o,
    output lc3b_l2_plru plru_update_c_o
);

    // Root bit picks the pair, the pair's bit picks the way within it.
    always_comb begin
        if (!plru_i[0]) victim_c_o = {1'b0, plru_i[1]};
        else            victim_c_o = {1'b1, plru_i[2]};
    end

    // Point every bit on the accessed way's path away from it; other bits keep.
    always_comb begin
        plru_update_c_o    = plru_i;
        plru_update_c_o[0] = ~access_way_i[1];
        if (!access_way_i[1]) plru_update_c_o[1] = ~access_way_i[0];
        else                  plru_update_c_o[2] = ~access_way_i[0];
    end

endmodule

// File: rtl/l2cache_control.sv
// L2 cache controller: hit/miss handling, dirty writeback, line fill, miss counter.
module l2cache_control
    import l2cache_control_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    l2cache_control_if.master bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CHECK     = 2'd1,
        WRITEBACK = 2'd2,
        ALLOCATE  = 2'd3
    } state_e;

    localparam l2_miss_count_t MISS_MAX = '1;

    state_e         state_q, state_d;
    lc3b_l2_way     victim_q, victim_d;
    l2_miss_count_t miss_count_q, miss_count_d;

    lc3b_l2_way     plru_victim_c;
    lc3b_l2_plru    plru_update_c;

    l2plru_logic u_plru (
        .plru_i          (bus.plru_out),
        .access_way_i    (bus.hit_way),
        .victim_c_o      (plru_victim_c),
        .plru_update_c_o (plru_update_c)
    );

    // State, latched victim and miss counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            victim_q     <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            victim_q     <= victim_d;
            miss_count_q <= miss_count_d;
        end
    end

    // Next-state logic and per-state control outputs.
    always_comb begin
        state_d            = state_q;
        victim_d           = victim_q;
        miss_count_d       = miss_count_q;
        bus.cpu_ack        = 1'b0;
        bus.mem_cyc        = 1'b0;
        bus.mem_stb        = 1'b0;
        bus.mem_we         = 1'b0;
        bus.plru_write     = 1'b0;
        bus.plru_in        = '0;
        bus.way_write      = '0;
        bus.valid_write    = '0;
        bus.valid_in       = 1'b0;
        bus.dirty_write    = '0;
        bus.dirty_in       = 1'b0;
        bus.datainmux_sel  = 1'b0;
        bus.memaddrmux_sel = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.cpu_cyc && bus.cpu_stb) state_d = CHECK;
            end

            CHECK: begin
                if (bus.hit) begin
                    bus.cpu_ack    = 1'b1;
                    bus.plru_write = 1'b1;
                    bus.plru_in    = plru_update_c;
                    if (bus.cpu_we) begin
                        bus.way_write     = way_onehot(bus.hit_way);
                        bus.dirty_write   = way_onehot(bus.hit_way);
                        bus.dirty_in      = 1'b1;
                        bus.datainmux_sel = 1'b1;
                    end
                    state_d = IDLE;
                end else begin
                    // Victim is frozen here and held until the fill writes it.
                    victim_d = plru_victim_c;
                    if (miss_count_q != MISS_MAX) begin
                        miss_count_d = miss_count_q + l2_miss_count_t'(1);
                    end
                    state_d = bus.victim_dirty ? WRITEBACK : ALLOCATE;
                end
            end

            WRITEBACK: begin
                // The memory transaction runs to completion regardless of cpu_cyc.
                bus.mem_cyc        = 1'b1;
                bus.mem_stb        = 1'b1;
                bus.mem_we         = 1'b1;
                bus.memaddrmux_sel = 1'b1;
                if (bus.mem_ack) state_d = ALLOCATE;
            end

            ALLOCATE: begin
                bus.mem_cyc = 1'b1;
                bus.mem_stb = 1'b1;
                if (bus.mem_ack) begin
                    bus.way_write   = way_onehot(victim_q);
                    bus.valid_write = way_onehot(victim_q);
                    bus.valid_in    = 1'b1;
                    bus.dirty_write = way_onehot(victim_q);
                    bus.dirty_in    = 1'b0;
                    state_d         = CHECK;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.victim_way = victim_q;
    assign bus.miss_count = miss_count_q;

endmodule

// File: tb/tb_l2cache_control.sv
// Bench for l2cache_control: hit table, hand-built miss/reset/saturation cases, random transactions.
module tb_l2cache_control;
    import l2cache_control_pkg::*;

    typedef struct packed {
        logic       cpu_ack;
        logic       mem_cyc;
        logic       mem_stb;
        logic       mem_we;
        logic       plru_write;
        logic [2:0] plru_in;
        logic [3:0] way_write;
        logic [3:0] valid_write;
        logic       valid_in;
        logic [3:0] dirty_write;
        logic       dirty_in;
        logic       datainmux_sel;
        logic       memaddrmux_sel;
    } outs_t;

    typedef struct {
        logic       we;
        logic [1:0] way;
        logic [2:0] plru;
        logic [2:0] exp_plru_in;
        logic [3:0] exp_way_write;
        logic [3:0] exp_dirty_write;
    } hit_vec_t;

    logic        clk = 1'b0;
    logic        rst;
    int          total = 0;
    int          bad   = 0;
    int unsigned ref_miss = 0;

    l2cache_control_if bus ();

    l2cache_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Tree PLRU as arithmetic: root bit set means the right pair (ways 2/3) is older.
    function automatic logic [1:0] ref_victim(input logic [2:0] p);
        int v;
        if (p[0]) v = 2 + int'(p[2]);
        else      v = int'(p[1]);
        return 2'(v);
    endfunction

    function automatic logic [2:0] ref_update(input logic [2:0] p, input logic [1:0] w);
        logic [2:0] r;
        bit         left;
        bit         even;
        r    = p;
        left = (int'(w) < 2);
        even = (int'(w) % 2 == 0);
        r[0] = left;
        if (left) r[1] = even;
        else      r[2] = even;
        return r;
    endfunction

    function automatic outs_t hit_expect(input logic we, input logic [1:0] w, input logic [2:0] p);
        outs_t e;
        e            = '0;
        e.cpu_ack    = 1'b1;
        e.plru_write = 1'b1;
        e.plru_in    = ref_update(p, w);
        if (we) begin
            e.way_write[w]   = 1'b1;
            e.dirty_write[w] = 1'b1;
            e.dirty_in       = 1'b1;
            e.datainmux_sel  = 1'b1;
        end
        return e;
    endfunction

    function automatic outs_t sample();
        outs_t a;
        a.cpu_ack        = bus.cpu_ack;
        a.mem_cyc        = bus.mem_cyc;
        a.mem_stb        = bus.mem_stb;
        a.mem_we         = bus.mem_we;
        a.plru_write     = bus.plru_write;
        a.plru_in        = bus.plru_in;
        a.way_write      = bus.way_write;
        a.valid_write    = bus.valid_write;
        a.valid_in       = bus.valid_in;
        a.dirty_write    = bus.dirty_write;
        a.dirty_in       = bus.dirty_in;
        a.datainmux_sel  = bus.datainmux_sel;
        a.memaddrmux_sel = bus.memaddrmux_sel;
        return a;
    endfunction

    // Compare all outputs; non-strict ignores data fields whose enable is expected low.
    task automatic cmp_outs(input string name, input outs_t exp, input bit strict);
        outs_t act;
        act = sample();
        if (!strict) begin
            if (!exp.plru_write)         begin act.plru_in = '0;          exp.plru_in = '0;          end
            if (exp.valid_write == '0)   begin act.valid_in = 1'b0;       exp.valid_in = 1'b0;       end
            if (exp.dirty_write == '0)   begin act.dirty_in = 1'b0;       exp.dirty_in = 1'b0;       end
            if (exp.way_write == '0)     begin act.datainmux_sel = 1'b0;  exp.datainmux_sel = 1'b0;  end
            if (!exp.mem_cyc)            begin act.memaddrmux_sel = 1'b0; exp.memaddrmux_sel = 1'b0; end
        end
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: outputs got=%h want=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One CPU request from an idle gap to the final acknowledge.
    task automatic run_txn(input logic we, input logic [1:0] way, input logic [2:0] p,
                           input bit miss, input logic vdirty, input int wb_lat,
                           input int al_lat, input bit drop_cyc,
                           input bit use_exp, input outs_t exp_hit);
        logic [1:0] vic;
        logic [1:0] final_way;
        outs_t      e;

        @(negedge clk);
        bus.cpu_cyc = 1'($urandom_range(0, 1));
        bus.cpu_stb = 1'b0;
        bus.hit     = 1'($urandom_range(0, 1));
        bus.mem_ack = 1'($urandom_range(0, 1));
        #2 cmp_outs("idle_gap", '0, 1'b1);

        @(negedge clk);
        bus.cpu_cyc = 1'b1;
        bus.cpu_stb = 1'b1;
        bus.cpu_we  = we;
        bus.mem_ack = 1'b0;
        #2 cmp_outs("idle_req", '0, 1'b1);

        @(negedge clk);
        bus.hit          = !miss;
        bus.hit_way      = way;
        bus.plru_out     = p;
        bus.victim_dirty = vdirty;
        #2;
        final_way = way;
        if (miss) begin
            cmp_outs("check_miss", '0, 1'b0);
            vic       = ref_victim(p);
            final_way = vic;
            if (ref_miss < 32'hFFFF) ref_miss++;
            if (vdirty) begin
                for (int k = 0; k <= wb_lat; k++) begin
                    @(negedge clk);
                    bus.hit = 1'($urandom_range(0, 1));
                    if (drop_cyc) begin
                        bus.cpu_cyc = 1'b0;
                        bus.cpu_stb = 1'b0;
                    end
                    bus.mem_ack = (k == wb_lat);
                    #2;
                    e                = '0;
                    e.mem_cyc        = 1'b1;
                    e.mem_stb        = 1'b1;
                    e.mem_we         = 1'b1;
                    e.memaddrmux_sel = 1'b1;
                    cmp_outs("writeback", e, 1'b0);
                    chk("wb_victim", 16'(bus.victim_way), 16'(vic));
                    chk("wb_miss_count", bus.miss_count, 16'(ref_miss));
                end
            end
            for (int k = 0; k <= al_lat; k++) begin
                @(negedge clk);
                bus.hit = 1'($urandom_range(0, 1));
                if (drop_cyc) begin
                    bus.cpu_cyc = 1'b0;
                    bus.cpu_stb = 1'b0;
                end
                bus.mem_ack = (k == al_lat);
                #2;
                e         = '0;
                e.mem_cyc = 1'b1;
                e.mem_stb = 1'b1;
                if (k == al_lat) begin
                    e.way_write[vic]   = 1'b1;
                    e.valid_write[vic] = 1'b1;
                    e.valid_in         = 1'b1;
                    e.dirty_write[vic] = 1'b1;
                    e.dirty_in         = 1'b0;
                    e.datainmux_sel    = 1'b0;
                end
                cmp_outs("allocate", e, 1'b0);
                chk("al_victim", 16'(bus.victim_way), 16'(vic));
                chk("al_miss_count", bus.miss_count, 16'(ref_miss));
            end
            @(negedge clk);
            bus.cpu_cyc  = 1'b1;
            bus.cpu_stb  = 1'b1;
            bus.mem_ack  = 1'b0;
            bus.hit      = 1'b1;
            bus.hit_way  = vic;
            bus.plru_out = p;
            #2;
        end
        if (use_exp) e = exp_hit;
        else         e = hit_expect(we, final_way, p);
        if (miss) cmp_outs("fill_hit", e, 1'b0);
        else      cmp_outs("check_hit", e, 1'b0);

        @(negedge clk);
        bus.cpu_cyc = 1'b0;
        bus.cpu_stb = 1'b0;
        bus.hit     = 1'b0;
        bus.mem_ack = 1'b0;
        #2 cmp_outs("ack_once", '0, 1'b1);
        chk("miss_count", bus.miss_count, 16'(ref_miss));
    endtask

    hit_vec_t hv[6];
    outs_t    e;

    initial begin
        // Hit table; expected PLRU values worked by hand from the update rule.
        // Accessing way 2 from 000 points the right-pair bit at way 3: 3'b100.
        hv[0] = '{we: 1'b0, way: 2'd2, plru: 3'b000, exp_plru_in: 3'b100, exp_way_write: 4'b0000, exp_dirty_write: 4'b0000};
        hv[1] = '{we: 1'b1, way: 2'd1, plru: 3'b000, exp_plru_in: 3'b001, exp_way_write: 4'b0010, exp_dirty_write: 4'b0010};
        hv[2] = '{we: 1'b0, way: 2'd0, plru: 3'b111, exp_plru_in: 3'b111, exp_way_write: 4'b0000, exp_dirty_write: 4'b0000};
        hv[3] = '{we: 1'b1, way: 2'd3, plru: 3'b010, exp_plru_in: 3'b010, exp_way_write: 4'b1000, exp_dirty_write: 4'b1000};
        hv[4] = '{we: 1'b0, way: 2'd1, plru: 3'b110, exp_plru_in: 3'b101, exp_way_write: 4'b0000, exp_dirty_write: 4'b0000};
        hv[5] = '{we: 1'b1, way: 2'd2, plru: 3'b011, exp_plru_in: 3'b110, exp_way_write: 4'b0100, exp_dirty_write: 4'b0100};

        rst              = 1'b1;
        bus.cpu_cyc      = 1'b0;
        bus.cpu_stb      = 1'b0;
        bus.cpu_we       = 1'b0;
        bus.mem_ack      = 1'b0;
        bus.hit          = 1'b0;
        bus.hit_way      = '0;
        bus.victim_dirty = 1'b0;
        bus.plru_out     = '0;

        repeat (2) @(negedge clk);
        #2 cmp_outs("reset_outputs", '0, 1'b1);
        chk("reset_miss_count", bus.miss_count, 16'h0000);
        chk("reset_victim", 16'(bus.victim_way), 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            e               = '0;
            e.cpu_ack       = 1'b1;
            e.plru_write    = 1'b1;
            e.plru_in       = hv[i].exp_plru_in;
            e.way_write     = hv[i].exp_way_write;
            e.dirty_write   = hv[i].exp_dirty_write;
            e.dirty_in      = hv[i].we;
            e.datainmux_sel = hv[i].we;
            run_txn(hv[i].we, hv[i].way, hv[i].plru, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, e);
        end
        chk("hits_no_miss_count", bus.miss_count, 16'h0000);

        // Clean miss, root bit set and right-pair bit set: way 3 is replaced.
        run_txn(1'b0, 2'd0, 3'b101, 1'b1, 1'b0, 0, 3, 1'b0, 1'b0, '0);
        chk("clean_miss_victim", 16'(bus.victim_way), 16'd3);
        chk("clean_miss_count", bus.miss_count, 16'd1);

        // Clean miss selecting way 2.
        run_txn(1'b0, 2'd1, 3'b011, 1'b1, 1'b0, 0, 1, 1'b0, 1'b0, '0);
        chk("clean_miss_way2", 16'(bus.victim_way), 16'd2);

        // Dirty write miss: five waiting writeback cycles, then fill of way 0.
        run_txn(1'b1, 2'd3, 3'b000, 1'b1, 1'b1, 5, 2, 1'b0, 1'b0, '0);
        chk("dirty_miss_victim", 16'(bus.victim_way), 16'd0);
        chk("dirty_miss_count", bus.miss_count, 16'd3);

        // CPU abandons the cycle mid-transaction; memory traffic must still finish.
        run_txn(1'b0, 2'd0, 3'b110, 1'b1, 1'b1, 2, 2, 1'b1, 1'b0, '0);

        // Reset in the middle of a fill.
        @(negedge clk);
        bus.cpu_cyc = 1'b1;
        bus.cpu_stb = 1'b1;
        bus.cpu_we  = 1'b0;
        bus.hit     = 1'b0;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        bus.plru_out     = 3'b011;
        bus.victim_dirty = 1'b0;
        @(negedge clk);
        #2 chk("pre_reset_mem_cyc", 16'(bus.mem_cyc), 16'd1);
        @(negedge clk);
        #1 rst = 1'b1;
        #1 cmp_outs("reset_mid_allocate", '0, 1'b1);
        chk("reset_mid_miss_count", bus.miss_count, 16'h0000);
        chk("reset_mid_victim", 16'(bus.victim_way), 16'h0000);
        @(negedge clk);
        rst         = 1'b0;
        bus.cpu_cyc = 1'b0;
        bus.cpu_stb = 1'b0;
        ref_miss    = 0;
        @(negedge clk);
        #2 cmp_outs("post_reset_idle", '0, 1'b1);

        // Saturation: preload just below the top, then three misses.
        @(negedge clk);
        force dut.miss_count_q = 16'hFFFE;
        #1 release dut.miss_count_q;
        #1 chk("preload_count", bus.miss_count, 16'hFFFE);
        ref_miss = 32'hFFFE;
        for (int i = 0; i < 3; i++) begin
            run_txn(1'b0, 2'd0, 3'($urandom_range(0, 7)), 1'b1, 1'($urandom_range(0, 1)), 1, 1, 1'b0, 1'b0, '0);
        end
        chk("saturated_count", bus.miss_count, 16'hFFFF);

        // Random transactions against the model.
        for (int n = 0; n < 40; n++) begin
            run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                    ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                    1'($urandom_range(0, 1)), 1'b0, '0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
